// File: rtl/mac_stream_ctrl.sv
// mac_stream_ctrl
// Initiator-side sequencer for a two-stage pipelined multiply-accumulate unit.
// Accepts a dot-product job (start + length), clears the MAC, streams operand
// pairs into it, waits out the MAC pipeline and returns the accumulated sum on
// a valid/ready result port.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_start, i_len             job request and pair count (sampled in idle only)
//   o_busy                     high whenever a job is in flight
//   i_op_valid, o_op_ready     operand stream handshake
//   i_op_a, i_op_b             unsigned operand pair
//   o_mac_en, o_mac_clr        MAC controls (never high together)
//   o_mac_a, o_mac_b           MAC operands, held while o_mac_en is low
//   i_mac_cout                 MAC accumulator value
//   o_res_valid, i_res_ready   result handshake
//   o_res_data                 captured dot product, held until next capture
module mac_stream_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_LEN    = 256,
  parameter int unsigned MAC_LAT    = 2,
  parameter int unsigned LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [LEN_W-1:0]        i_len,
  output logic                    o_busy,
  input  logic                    i_op_valid,
  output logic                    o_op_ready,
  input  logic [DATA_WIDTH-1:0]   i_op_a,
  input  logic [DATA_WIDTH-1:0]   i_op_b,
  output logic                    o_mac_en,
  output logic                    o_mac_clr,
  output logic [DATA_WIDTH-1:0]   o_mac_a,
  output logic [DATA_WIDTH-1:0]   o_mac_b,
  input  logic [3*DATA_WIDTH-1:0] i_mac_cout,
  output logic                    o_res_valid,
  input  logic                    i_res_ready,
  output logic [3*DATA_WIDTH-1:0] o_res_data
);

  // Drain lasts MAC_LAT+1 cycles: the cycle carrying the last mac_en plus the
  // MAC pipeline latency until mac_cout reflects that product.
  localparam int unsigned DRAIN_W = $clog2(MAC_LAT + 1) + 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MAC_LAT);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StStream,
    StDrain,
    StResult
  } state_e;

  state_e                    r_state;
  state_e                    w_state_next;
  logic [LEN_W-1:0]          r_len;
  logic [LEN_W-1:0]          r_cnt;
  logic [LEN_W-1:0]          w_cnt_inc;
  logic [DRAIN_W-1:0]        r_drain_cnt;
  logic                      r_mac_en;
  logic [DATA_WIDTH-1:0]     r_mac_a;
  logic [DATA_WIDTH-1:0]     r_mac_b;
  logic [3*DATA_WIDTH-1:0]   r_res_data;
  logic                      w_beat;
  logic                      w_capture;

  assign w_cnt_inc = r_cnt + LEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_beat       = 1'b0;
    w_capture    = 1'b0;
    o_busy       = 1'b1;
    o_op_ready   = 1'b0;
    o_mac_clr    = 1'b0;
    o_res_valid  = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_busy = 1'b0;
        if (i_start) w_state_next = StClear;
      end
      StClear: begin
        o_mac_clr    = 1'b1;
        w_state_next = (r_len == '0) ? StDrain : StStream;
      end
      StStream: begin
        o_op_ready = 1'b1;
        w_beat     = i_op_valid;
        if (w_beat && (w_cnt_inc == r_len)) w_state_next = StDrain;
      end
      StDrain: begin
        if (r_drain_cnt == DRAIN_LAST) begin
          w_capture    = 1'b1;
          w_state_next = StResult;
        end
      end
      StResult: begin
        o_res_valid = 1'b1;
        if (i_res_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len       <= '0;
      r_cnt       <= '0;
      r_drain_cnt <= '0;
      r_mac_en    <= 1'b0;
      r_mac_a     <= '0;
      r_mac_b     <= '0;
      r_res_data  <= '0;
    end else begin
      // mac_en follows a beat by exactly one cycle, alongside its operands.
      r_mac_en <= w_beat;
      if (w_beat) begin
        r_mac_a <= i_op_a;
        r_mac_b <= i_op_b;
      end

      if ((r_state == StIdle) && i_start) begin
        r_len <= i_len;
        r_cnt <= '0;
      end else if (w_beat) begin
        r_cnt <= w_cnt_inc;
      end

      if (r_state == StDrain) begin
        r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
      end else begin
        r_drain_cnt <= '0;
      end

      if (w_capture) r_res_data <= i_mac_cout;
    end
  end

  assign o_mac_en   = r_mac_en;
  assign o_mac_a    = r_mac_a;
  assign o_mac_b    = r_mac_b;
  assign o_res_data = r_res_data;

endmodule

// File: tb/tb_mac_stream_ctrl.sv
// Self-checking bench for mac_stream_ctrl with a two-stage MAC model.
module tb_mac_stream_ctrl;
  localparam int DW    = 8;
  localparam int LEN_W = 9;
  localparam int RW    = 3 * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic          busy;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [DW-1:0] op_a = '0;
  logic [DW-1:0] op_b = '0;
  logic          mac_en;
  logic          mac_clr;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic [RW-1:0] mac_cout;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [RW-1:0] res_data;

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt   = 0;
  int clr_cnt  = 0;
  logic [RW-1:0] exp_q[$];
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];

  always #5 clk = ~clk;

  mac_stream_ctrl #(
    .DATA_WIDTH(DW),
    .MAX_LEN   (256),
    .MAC_LAT   (2),
    .LEN_W     (LEN_W)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (start),
    .i_len      (len),
    .o_busy     (busy),
    .i_op_valid (op_valid),
    .o_op_ready (op_ready),
    .i_op_a     (op_a),
    .i_op_b     (op_b),
    .o_mac_en   (mac_en),
    .o_mac_clr  (mac_clr),
    .o_mac_a    (mac_a),
    .o_mac_b    (mac_b),
    .i_mac_cout (mac_cout),
    .o_res_valid(res_valid),
    .i_res_ready(res_ready),
    .o_res_data (res_data)
  );

  // Two-stage MAC: stage 1 registers product and controls, stage 2 accumulates.
  logic [2*DW-1:0] m_prod;
  logic            m_en_d;
  logic            m_clr_d;
  logic [RW-1:0]   m_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prod  <= '0;
      m_en_d  <= 1'b0;
      m_clr_d <= 1'b0;
      m_acc   <= '0;
    end else begin
      m_prod  <= (2*DW)'(mac_a) * (2*DW)'(mac_b);
      m_en_d  <= mac_en;
      m_clr_d <= mac_clr;
      if (m_clr_d) m_acc <= '0;
      else if (m_en_d) m_acc <= m_acc + RW'(m_prod);
    end
  end
  assign mac_cout = m_acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mac_en) en_cnt++;
      if (mac_clr) clr_cnt++;
      check("clr_en_excl", 64'(mac_clr & mac_en), 64'd0);
    end
  end

  // Runs one job from qa/qb; optional result backpressure with a start poke.
  task automatic run_job(input int n, input bit bubbles, input int hold, input bit poke);
    logic [RW-1:0] sum;
    logic [RW-1:0] held;
    int idx;
    int cyc;
    int lat;
    bit tog;
    bit beat;
    bit seen;
    sum = '0;
    for (int i = 0; i < n; i++) sum = sum + RW'(qa[i]) * RW'(qb[i]);
    exp_q.push_back(sum);

    @(posedge clk); #1;
    en_cnt  = 0;
    clr_cnt = 0;
    start   = 1'b1;
    len     = LEN_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    len   = '0;
    idx   = 0;
    cyc   = 0;
    tog   = 1'b1;
    if (n > 0) begin
      op_valid = 1'b1;
      op_a     = qa[0];
      op_b     = qb[0];
    end
    while (idx < n && cyc < 4000) begin
      @(negedge clk);
      beat = op_valid && op_ready;
      @(posedge clk); #1;
      cyc++;
      if (beat) idx++;
      if (idx < n) begin
        if (bubbles) tog = ~tog;
        op_valid = bubbles ? tog : 1'b1;
        op_a     = qa[idx];
        op_b     = qb[idx];
      end else begin
        op_valid = 1'b0;
      end
    end
    op_valid = 1'b0;
    check("feed_done", 64'(idx), 64'(n));

    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 50) begin
      @(negedge clk);
      lat++;
      seen = res_valid;
    end
    check("res_latency", 64'(lat), (n == 0) ? 64'd5 : 64'd4);

    held = res_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      start = poke && (i == 2);
      @(negedge clk);
      check("hold_valid", 64'(res_valid), 64'd1);
      check("hold_data", 64'(res_data), 64'(held));
      check("hold_busy", 64'(busy), 64'd1);
    end
    @(posedge clk); #1;
    start     = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check("res_valid", 64'(res_valid), 64'd1);
    if (res_valid && res_ready && exp_q.size() > 0) begin
      check("res_data", 64'(res_data), 64'(exp_q.pop_front()));
    end
    held = res_data;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("data_after_hs", 64'(res_data), 64'(held));
    check("en_count", 64'(en_cnt), 64'(n));
    check("clr_count", 64'(clr_cnt), 64'd1);
  endtask

  initial begin
    int idx;
    int cyc;
    bit beat;

    // Reset with random inputs, start included.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      start     = 1'($urandom);
      len       = LEN_W'($urandom);
      op_valid  = 1'($urandom);
      op_a      = DW'($urandom);
      op_b      = DW'($urandom);
      res_ready = 1'($urandom);
      @(negedge clk);
      check("rst_outputs", 64'({busy, op_ready, mac_en, mac_clr, mac_a, mac_b, res_valid,
                                res_data}), 64'd0);
    end
    @(posedge clk); #1;
    start     = 1'b0;
    len       = '0;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    res_ready = 1'b0;
    rst_n     = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", 64'({busy, op_ready, res_valid}), 64'd0);
    end

    // Basic job: 1*2+2*2+3*2+4*2 = 20.
    qa = {8'd1, 8'd2, 8'd3, 8'd4};
    qb = {8'd2, 8'd2, 8'd2, 8'd2};
    run_job(4, 1'b0, 0, 1'b0);

    // Bubbles plus result backpressure and an ignored start: 3*65025 = 195075.
    qa = {8'd255, 8'd255, 8'd255};
    qb = {8'd255, 8'd255, 8'd255};
    run_job(3, 1'b1, 10, 1'b1);

    // Empty job.
    qa.delete();
    qb.delete();
    run_job(0, 1'b0, 0, 1'b0);

    // Full-length job: 256*65025 = 16646400.
    for (int i = 0; i < 256; i++) begin
      qa.push_back(8'd255);
      qb.push_back(8'd255);
    end
    run_job(256, 1'b0, 0, 1'b0);

    // Reset mid-stream after 2 of 5 beats.
    @(posedge clk); #1;
    start = 1'b1;
    len   = LEN_W'(5);
    @(posedge clk); #1;
    start    = 1'b0;
    len      = '0;
    op_valid = 1'b1;
    op_a     = 8'd7;
    op_b     = 8'd9;
    idx      = 0;
    cyc      = 0;
    while (idx < 2 && cyc < 50) begin
      @(negedge clk);
      beat = op_valid && op_ready;
      @(posedge clk); #1;
      cyc++;
      if (beat) idx++;
    end
    check("midrst_beats", 64'(idx), 64'd2);
    rst_n    = 1'b0;
    op_valid = 1'b0;
    #1;
    check("midrst_outputs", 64'({busy, op_ready, mac_en, mac_clr, mac_a, mac_b, res_valid,
                                 res_data}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle", 64'(busy), 64'd0);

    // Follow-up job: 3*3+4*4 = 25.
    qa = {8'd3, 8'd4};
    qb = {8'd3, 8'd4};
    run_job(2, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_stream_ctrl.md
# mac_stream_ctrl

Sequencer that drives the two-stage pipelined multiply-accumulate unit from the initiator side. It accepts a dot-product job (start + length), pulls operand pairs from a valid/ready stream, and issues the MAC's clear and enable controls with operands. It waits out the MAC pipeline latency, captures the accumulated result, and returns it on a valid/ready result port. It sits between the operand source (FIFO/memory reader) and one MAC instance.

## Interface
- DATA_WIDTH, 8, operand width; MAC result width is 3*DATA_WIDTH
- MAX_LEN, 256, maximum operand pairs per job
- MAC_LAT, 2, cycles from the cycle mac_en is high until mac_cout reflects that product (fixed by the MAC's two stages)
- LEN_W, $clog2(MAX_LEN+1), width of len (derived)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  job request, sampled only in IDLE
- len  in  LEN_W  pairs in job, sampled with start; 0..MAX_LEN
- busy  out  1  high in every state except IDLE
- op_valid  in  1  operand pair valid
- op_ready  out  1  block accepts pair
- op_a, op_b  in  DATA_WIDTH  operands (unsigned)
- mac_en  out  1  MAC enable
- mac_clr  out  1  MAC clear
- mac_a, mac_b  out  DATA_WIDTH  MAC operands
- mac_cout  in  3*DATA_WIDTH  MAC accumulator
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_data  out  3*DATA_WIDTH  captured dot product

## Operation
- All outputs are registered or decoded from state flops; reset value 0 for every output; FSM resets to IDLE.
- IDLE: op_ready=0, res_valid=0. start=1 latches len, zeroes beat counter, goes to CLEAR. start outside IDLE is ignored.
- CLEAR (1 cycle): mac_clr=1, mac_en=0. Next: STREAM if len!=0, else DRAIN.
- STREAM: op_ready=1. Each op_valid&&op_ready beat registers op_a/op_b onto mac_a/mac_b and sets mac_en=1 for exactly the next cycle; a cycle without a beat gives mac_en=0 next cycle. On the beat that makes count==len, op_ready drops the following cycle and the FSM goes to DRAIN.
- DRAIN: MAC_LAT+1 cycles (drain counter), op_ready=0. At the edge ending the last DRAIN cycle, res_data<=mac_cout; go to RESULT.
- RESULT: res_valid=1, res_data stable until res_valid&&res_ready; then IDLE. res_data holds its value after the handshake until the next capture.
- mac_a/mac_b hold their last value when mac_en=0. mac_clr and mac_en are never high in the same cycle.
- Arithmetic is done in the MAC: unsigned, wraps modulo 2^(3*DATA_WIDTH). With defaults, MAX_LEN pairs of 255*255 = 16,646,400, which does not overflow. The block passes mac_cout through unmodified.
- rst_n low at any time, including mid-job: outputs go to 0 and the FSM goes to IDLE immediately. The partial job is discarded. The MAC is reset by the same rst_n.

## Timing
- start in cycle s: mac_clr=1 in cycle s+1; op_ready=1 from s+2, so the first beat can be accepted in s+2.
- The MAC clears at the end of s+2. The first add completes at the end of s+4 or later, so no clear/add conflict occurs.
- Last beat accepted in cycle n: mac_en=1 in n+1; DRAIN covers n+1..n+1+MAC_LAT; capture at end of n+3 (default); res_valid=1 from n+4.
- len=0: start in s → CLEAR s+1 → DRAIN s+2..s+4 → res_valid=1 in s+5 with res_data=0.
- Throughput: one pair per cycle in STREAM with continuous op_valid. Earliest next start is the cycle after the result handshake.

## Test plan
- Reset: hold rst_n low with random inputs → all outputs 0, busy=0; start asserted during reset is ignored.
- Basic job: len=4, pairs (1,2),(2,2),(3,2),(4,2) with op_valid held high → exactly one mac_clr cycle, 4 mac_en cycles, res_data=20, res_valid 4 cycles after the last beat.
- Bubbles: len=3, op_valid toggled 1/0, all pairs (255,255) → exactly 3 mac_en pulses, res_data=195075.
- Result backpressure: res_ready low for 10 cycles → res_valid and res_data stable; start pulsed during RESULT is ignored (busy stays 1, no mac_clr).
- Boundaries: len=0 → res_data=0 with no mac_en; len=256 with all (255,255) → res_data=16646400.
- Reset mid-STREAM after 2 of 5 beats → outputs 0 immediately; a following len=2 job with (3,3),(4,4) gives res_data=25.
- The bench models the MAC with its 2-stage behavior (Clr has priority over En; 1-cycle delay on En/Clr and product).
